// File: rtl/ysyx_22040175_mem_arbiter.sv
// ysyx_22040175_mem_arbiter
//   Shares one memory bus port between instruction fetch (if_*) and the
//   load/store path (mem_*). One transaction is outstanding at a time. The
//   winning request is latched, held on the bus until bus_req_ready, and the
//   bus response is routed back to the owner as a one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   if_req_*  / if_rsp_*       fetch request (valid/addr/ready) and response
//   mem_req_* / mem_rsp_*      data request (valid/we/addr/wdata/wmask/ready)
//                              and response
//   bus_req_* / bus_rsp_*      shared bus request (latched fields) and response
//   busy                       FSM not in IDLE
//   owner                      owner of current/last transaction (0 fetch, 1 data)
//
// Build option
//   ARB_STARVE_GUARD_EN        when defined, after STARVE_LIM consecutive data
//                              grants made while fetch was waiting, one fetch
//                              grant is forced.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transaction; grant evaluated combinationally
// REQ      | bus_req_valid high, latched fields held until bus_req_ready
// WAIT_RSP | request accepted by bus; waiting for bus_rsp_valid

module ysyx_22040175_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              mem_req_valid,
  input  logic              mem_req_we,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_wdata,
  input  logic [7:0]        mem_req_wmask,
  output logic              mem_req_ready,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic              bus_req_valid,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [7:0]        bus_req_wmask,
  input  logic              bus_req_ready,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          wmask_q, wmask_d;
  logic                owner_q, owner_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic                mem_rsp_valid_q, mem_rsp_valid_d;
  logic [DATA_W-1:0]   if_rsp_data_q, if_rsp_data_d;
  logic [DATA_W-1:0]   mem_rsp_data_q, mem_rsp_data_d;

  logic in_idle;
  logic force_if;
  logic grant_if;
  logic grant_mem;

  assign in_idle = (state_q == S_IDLE);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIM) + 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STARVE_MAX) && if_req_valid && mem_req_valid;

  // Counts data grants that left a pending fetch behind; saturates.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req_valid && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign grant_mem = in_idle && mem_req_valid && !force_if;
  assign grant_if  = in_idle && if_req_valid && (!mem_req_valid || force_if);

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    owner_d         = owner_q;
    if_rsp_valid_d  = 1'b0;
    mem_rsp_valid_d = 1'b0;
    if_rsp_data_d   = if_rsp_data_q;
    mem_rsp_data_d  = mem_rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          we_d    = mem_req_we;
          addr_d  = mem_req_addr;
          wdata_d = mem_req_wdata;
          wmask_d = mem_req_wmask;
          owner_d = 1'b1;
          state_d = S_REQ;
        end else if (grant_if) begin
          we_d    = 1'b0;
          addr_d  = if_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus_rsp_valid) begin
          if (owner_q) begin
            mem_rsp_valid_d = 1'b1;
            mem_rsp_data_d  = bus_rsp_data;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = bus_rsp_data;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      owner_q         <= 1'b0;
      if_rsp_valid_q  <= 1'b0;
      mem_rsp_valid_q <= 1'b0;
      if_rsp_data_q   <= '0;
      mem_rsp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      owner_q         <= owner_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      mem_rsp_valid_q <= mem_rsp_valid_d;
      if_rsp_data_q   <= if_rsp_data_d;
      mem_rsp_data_q  <= mem_rsp_data_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign mem_req_ready = grant_mem;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign mem_rsp_valid = mem_rsp_valid_q;
  assign mem_rsp_data  = mem_rsp_data_q;
  assign bus_req_valid = (state_q == S_REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wmask = wmask_q;
  assign busy          = !in_idle;
  assign owner         = owner_q;

endmodule

// File: tb/tb_ysyx_22040175_mem_arbiter.sv
module tb_ysyx_22040175_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [63:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_we = 1'b0;
  logic [63:0] mem_req_addr = '0;
  logic [63:0] mem_req_wdata = '0;
  logic [7:0]  mem_req_wmask = '0;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        bus_req_valid;
  logic        bus_req_we;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wmask;
  logic        bus_req_ready = 1'b0;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rsp_data = '0;
  logic        busy;
  logic        owner;

  ysyx_22040175_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .bus_req_valid(bus_req_valid), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask), .bus_req_ready(bus_req_ready),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t q_if[$];
  exp_t q_mem[$];
  exp_t e_if, e_mem;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Response monitor: every rsp pulse must match the head of its queue,
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rsp_valid) begin
        if (q_if.size() == 0) begin
          total++; bad++;
          $display("FAIL if_rsp_unexpected: got data %h want no response", if_rsp_data);
        end else begin
          e_if = q_if.pop_front();
          chk("if_rsp_data", if_rsp_data, e_if.data);
          chk("if_rsp_cycle", 64'(cyc_cnt), 64'(e_if.cyc));
        end
      end
      if (mem_rsp_valid) begin
        if (q_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_rsp_unexpected: got data %h want no response", mem_rsp_data);
        end else begin
          e_mem = q_mem.pop_front();
          chk("mem_rsp_data", mem_rsp_data, e_mem.data);
          chk("mem_rsp_cycle", 64'(cyc_cnt), 64'(e_mem.cyc));
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit to_mem, input logic [63:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc_cnt + 1;
    if (to_mem) q_mem.push_back(e);
    else        q_if.push_back(e);
  endtask

  // Starts in IDLE just after a rising edge; returns in the cycle where the
  // response pulse is due (arbiter back in IDLE).
  task automatic run_txn(input bit is_mem, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic [63:0] rdata, input int stall, input bit stray);
    logic        e_we;
    logic [63:0] e_wdata;
    logic [7:0]  e_wmask;
    e_we    = is_mem ? we : 1'b0;
    e_wdata = is_mem ? wdata : 64'h0;
    e_wmask = is_mem ? wmask : 8'h0;
    if (is_mem) begin
      mem_req_valid = 1'b1; mem_req_we = we; mem_req_addr = addr;
      mem_req_wdata = wdata; mem_req_wmask = wmask;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    @(negedge clk);
    chk("grant_ready", is_mem ? mem_req_ready : if_req_ready, 1);
    chk("other_ready", is_mem ? if_req_ready : mem_req_ready, 0);
    cyc;
    if (is_mem) begin
      mem_req_valid = 1'b0; mem_req_we = ~we; mem_req_addr = ~addr;
      mem_req_wdata = ~wdata; mem_req_wmask = ~wmask;
    end else begin
      if_req_valid = 1'b0; if_req_addr = ~addr;
    end
    for (int i = 0; i <= stall; i++) begin
      bus_req_ready = (i == stall);
      bus_rsp_valid = stray && (i < stall);
      bus_rsp_data  = 64'hBAD0_BAD0;
      @(negedge clk);
      chk("req_bus_valid", bus_req_valid, 1);
      chk("req_bus_addr", bus_req_addr, addr);
      chk("req_bus_we", bus_req_we, e_we);
      chk("req_bus_wdata", bus_req_wdata, e_wdata);
      chk("req_bus_wmask", bus_req_wmask, e_wmask);
      chk("req_owner", owner, is_mem);
      chk("req_busy", busy, 1);
      chk("req_readies", {if_req_ready, mem_req_ready}, 0);
      chk("req_no_rsp", {if_rsp_valid, mem_rsp_valid}, 0);
      cyc;
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = rdata;
    push_exp(is_mem, rdata);
    @(negedge clk);
    chk("wait_bus_valid", bus_req_valid, 0);
    chk("wait_busy", busy, 1);
    cyc;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = 64'h0;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no end of stimulus want end before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit exp_f;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_valid", bus_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_bus_fields", {bus_req_we, bus_req_wmask} | bus_req_addr | bus_req_wdata, 0);
    chk("rst_rsp", {if_rsp_valid, mem_rsp_valid}, 0);
    chk("rst_rsp_data", if_rsp_data | mem_rsp_data, 0);
    rst_n = 1'b1;
    cyc;

    // Fetch only, minimum latency
    run_txn(0, 0, 64'h8000_0000, 64'h0, 8'h0, 64'h0000_0413, 0, 0);

    // Simultaneous fetch and load: data first, fetch accepted in the response cycle
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0004;
    run_txn(1, 0, 64'h8000_1000, 64'h0, 8'h0, 64'h1122_3344_5566_7788, 0, 0);
    run_txn(0, 0, 64'h8000_0004, 64'h0, 8'h0, 64'h0000_0097, 0, 0);

    // Store with 3 cycles of bus backpressure
    run_txn(1, 1, 64'h8000_3000, 64'hDEAD_BEEF, 8'h0F, 64'h0000_A5A5, 3, 0);

    // Stray response in IDLE
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'hFFFF_0000;
    @(negedge clk);
    chk("stray_idle_busy", busy, 0);
    cyc;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_idle_rsp", {if_rsp_valid, mem_rsp_valid}, 0);
    chk("stray_idle_state", {busy, bus_req_valid}, 0);
    cyc;

    // Stray response while in REQ
    run_txn(0, 0, 64'h8000_0100, 64'h0, 8'h0, 64'h0000_0013, 2, 1);
    cyc;

    // Reset while in WAIT_RSP
    mem_req_valid = 1'b1; mem_req_we = 1'b0; mem_req_addr = 64'h8000_2000;
    mem_req_wdata = 64'h0; mem_req_wmask = 8'h0;
    @(negedge clk);
    chk("rstw_grant", mem_req_ready, 1);
    cyc;
    mem_req_valid = 1'b0;
    bus_req_ready = 1'b1;
    cyc;
    bus_req_ready = 1'b0;
    @(negedge clk);
    chk("rstw_in_wait", {busy, bus_req_valid}, 2'b10);
    cyc;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_owner", owner, 0);
    chk("rstw_bus_valid", bus_req_valid, 0);
    chk("rstw_bus_addr", bus_req_addr, 0);
    chk("rstw_rsp_data", if_rsp_data | mem_rsp_data, 0);
    chk("rstw_rsp_valid", {if_rsp_valid, mem_rsp_valid}, 0);
    cyc;
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'h7777_7777;
    @(negedge clk);
    chk("rstw_late_busy", busy, 0);
    cyc;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rstw_late_rsp", {if_rsp_valid, mem_rsp_valid}, 0);
    cyc;

    // Both requesters held valid continuously
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0200;
    mem_req_valid = 1'b1;
    mem_req_we    = 1'b0;
    mem_req_addr  = 64'h8000_4000;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_f = ((i % 5) == 4);
`else
      exp_f = 1'b0;
`endif
      @(negedge clk);
      chk("starve_if_ready", if_req_ready, exp_f);
      chk("starve_mem_ready", mem_req_ready, !exp_f);
      cyc;
      bus_req_ready = 1'b1;
      @(negedge clk);
      chk("starve_owner", owner, !exp_f);
      cyc;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = 64'h5000 + 64'(i);
      push_exp(!exp_f, 64'h5000 + 64'(i));
      cyc;
      bus_rsp_valid = 1'b0;
    end
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;

    repeat (3) cyc;
    chk("q_if_drained", 64'(q_if.size()), 0);
    chk("q_mem_drained", 64'(q_mem.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
